m_stage_dmem: RTL

- Data memory for the M stage of the 5-stage pipelined MIPS core.
- Performs word, halfword and byte stores, and returns sign- or zero-extended load data.
- Load data feeds the MW pipeline register's read-data input.
- Reads are asynchronous; writes commit on the clock edge, so a load issued in M has its result ready before the MW edge.

---
 rtl/m_stage_dmem_pkg.sv | 13 +
 rtl/m_stage_dmem_ext.sv | 29 ++
 rtl/m_stage_dmem.sv | 59 +++++
 3 files changed

// File: rtl/m_stage_dmem_pkg.sv
// m_stage_dmem_pkg: memory-op encodings and default base address shared by the M-stage data memory
package m_stage_dmem_pkg;
  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LW   = 4'd1;
  localparam logic [3:0] MEM_OP_LH   = 4'd2;
  localparam logic [3:0] MEM_OP_LHU  = 4'd3;
  localparam logic [3:0] MEM_OP_LB   = 4'd4;
  localparam logic [3:0] MEM_OP_LBU  = 4'd5;
  localparam logic [3:0] MEM_OP_SW   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SB   = 4'd8;
  localparam logic [31:0] DMEM_ADDR_BASE = 32'h0000_0000;
endpackage

// File: rtl/m_stage_dmem_ext.sv
// m_stage_dmem_ext: load lane select with sign/zero extension, and store byte-merge into the old word
module m_stage_dmem_ext
  import m_stage_dmem_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);
  logic [15:0] half;
  logic [7:0]  byte_v;
  logic [4:0]  sh;
  // Extract the addressed half/byte and build both the load result and the merged store word
  always_comb begin
    sh     = {lane_i, 3'b000};
    half   = lane_i[1] ? word_i[31:16] : word_i[15:0];
    byte_v = 8'(word_i >> sh);
    rdata_o = op_i == MEM_OP_LW  ? word_i :
              op_i == MEM_OP_LH  ? {{16{half[15]}}, half} :
              op_i == MEM_OP_LHU ? {16'b0, half} :
              op_i == MEM_OP_LB  ? {{24{byte_v[7]}}, byte_v} :
              op_i == MEM_OP_LBU ? {24'b0, byte_v} : '0;
    merged_o = op_i == MEM_OP_SW ? wdata_i :
               op_i == MEM_OP_SH ? (lane_i[1] ? {wdata_i[15:0], word_i[15:0]} : {word_i[31:16], wdata_i[15:0]}) :
               op_i == MEM_OP_SB ? ((word_i & ~(32'hFF << sh)) | ({24'b0, wdata_i[7:0]} << sh)) : word_i;
  end
endmodule

// File: rtl/m_stage_dmem.sv
// m_stage_dmem: M-stage data memory, async read / sync write, store logging under DMEM_LOG_EN
module m_stage_dmem
  import m_stage_dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE   = DMEM_ADDR_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [3:0]  M_mem_op,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_wdata,
  output logic [31:0] M_rdata,
  output logic        M_mem_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off;
  logic [AW-1:0] widx;
  logic          in_range, is_word, is_half, is_byte, is_store, aligned;
  logic [31:0]   rd_word, ext_rdata, merged;
  // Address decode, alignment/range error and gated load result
  always_comb begin
    off       = M_addr - ADDR_BASE;
    widx      = off[AW+1:2];
    in_range  = {2'b00, off[31:2]} < 32'(DEPTH_WORDS);
    is_word   = M_mem_op == MEM_OP_LW || M_mem_op == MEM_OP_SW;
    is_half   = M_mem_op == MEM_OP_LH || M_mem_op == MEM_OP_LHU || M_mem_op == MEM_OP_SH;
    is_byte   = M_mem_op == MEM_OP_LB || M_mem_op == MEM_OP_LBU || M_mem_op == MEM_OP_SB;
    is_store  = M_mem_op == MEM_OP_SW || M_mem_op == MEM_OP_SH || M_mem_op == MEM_OP_SB;
    aligned   = is_word ? off[1:0] == 2'b00 : is_half ? !off[0] : 1'b1;
    M_mem_err = (is_word || is_half || is_byte) && (!in_range || !aligned);
    rd_word   = in_range ? mem[widx] : '0;
    M_rdata   = M_mem_err ? '0 : ext_rdata;
  end
  m_stage_dmem_ext u_ext (
    .op_i     (M_mem_op),
    .lane_i   (off[1:0]),
    .word_i   (rd_word),
    .wdata_i  (M_wdata),
    .rdata_o  (ext_rdata),
    .merged_o (merged)
  );
  // Reset clears the whole array; otherwise a legal store writes back the merged word
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    else if (is_store && !M_mem_err) mem[widx] <= merged;
  end
`ifdef DMEM_LOG_EN
  // Trace each committed store as the full word written back
  always_ff @(posedge clk) begin
    if (!reset && is_store && !M_mem_err) $display("@%h: *%h <= %h", M_PC, ADDR_BASE + {off[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^M_PC;
`endif
endmodule
